// File: rtl/thread_pkg.sv
// rtl/thread_pkg.sv - shared thread datapath widths and types
package thread_pkg;
   localparam int DATA_W   = 28;
   localparam int NUM_REGS = 16;
   localparam int SEL_W    = $clog2(NUM_REGS);

   typedef logic [SEL_W-1:0]  reg_idx_t;
   typedef logic [DATA_W-1:0] data_word_t;
endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - NUM_REGS:1 combinational read mux, index 0 reads as zero
module rf_read_port
   import thread_pkg::*;
#(
   parameter int DATA_W   = thread_pkg::DATA_W,
   parameter int NUM_REGS = thread_pkg::NUM_REGS,
   parameter int SEL_W    = thread_pkg::SEL_W
) (
   input  logic [DATA_W-1:0] regs_i [NUM_REGS],
   input  logic [SEL_W-1:0]  sel_i,
   output logic [DATA_W-1:0] dout_o
);

   // Zero is forced here so the port never depends on what feeds entry 0.
   always_comb begin
      dout_o = '0;
      if (sel_i != '0) begin
         dout_o = regs_i[sel_i];
      end
   end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 16x28 thread register file, two async read ports, one sync write port
module register_file
   import thread_pkg::*;
#(
   parameter int DATA_W   = thread_pkg::DATA_W,
   parameter int NUM_REGS = thread_pkg::NUM_REGS,
   parameter int SEL_W    = thread_pkg::SEL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [SEL_W-1:0]  rs0,
   input  logic [SEL_W-1:0]  rs1,
   input  logic [DATA_W-1:0] data_in,
   input  logic [SEL_W-1:0]  dest_sel,
   input  logic              wen,
   output logic [DATA_W-1:0] dout0,
   output logic [DATA_W-1:0] dout1
);

   logic [DATA_W-1:0] rf_all [NUM_REGS];

   // R0 has no storage; the slot is tied off for the read muxes.
   assign rf_all[0] = '0;

   for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
      logic [DATA_W-1:0] rf_q;
      logic [DATA_W-1:0] rf_d;
      logic              we;

      assign we = wen && (dest_sel == SEL_W'(i));

      always_comb begin
         rf_d = rf_q;
         if (we) begin
            rf_d = data_in;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rf_q <= '0;
         end else begin
            rf_q <= rf_d;
         end
      end

      assign rf_all[i] = rf_q;
   end

   rf_read_port #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .SEL_W    (SEL_W)
   ) u_read_port0 (
      .regs_i (rf_all),
      .sel_i  (rs0),
      .dout_o (dout0)
   );

   rf_read_port #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .SEL_W    (SEL_W)
   ) u_read_port1 (
      .regs_i (rf_all),
      .sel_i  (rs1),
      .dout_o (dout1)
   );

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
`timescale 1ns/100ps
module tb_register_file;

   logic        clk;
   logic        rst;
   logic [3:0]  rs0;
   logic [3:0]  rs1;
   logic [27:0] data_in;
   logic [3:0]  dest_sel;
   logic        wen;
   logic [27:0] dout0;
   logic [27:0] dout1;

   int checks;
   int failures;

   register_file dut (
      .clk      (clk),
      .rst      (rst),
      .rs0      (rs0),
      .rs1      (rs1),
      .data_in  (data_in),
      .dest_sel (dest_sel),
      .wen      (wen),
      .dout0    (dout0),
      .dout1    (dout1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_write(input logic [3:0] sel, input logic [27:0] data);
      @(negedge clk);
      dest_sel = sel;
      data_in  = data;
      wen      = 1'b1;
      @(posedge clk);
      #1;
      wen = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rs0 = 4'd0;
      rs1 = 4'd1;
      @(posedge clk);
      #1;
      checks++;
      if (dout0 !== 28'h0 || dout1 !== 28'h0) begin
         failures++;
         $display("FAIL reset_held dout0=%h dout1=%h expected 0 0", dout0, dout1);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (dout0 !== 28'h0 || dout1 !== 28'h0) begin
         failures++;
         $display("FAIL reset_release dout0=%h dout1=%h expected 0 0", dout0, dout1);
      end
   endtask

   task automatic test_r0_protect();
      do_write(4'd0, 28'h00ABCDE);
      rs0 = 4'd0;
      rs1 = 4'd0;
      #1;
      checks++;
      if (dout0 !== 28'h0 || dout1 !== 28'h0) begin
         failures++;
         $display("FAIL r0_protect dout0=%h dout1=%h expected 0 0", dout0, dout1);
      end
   endtask

   task automatic test_basic();
      do_write(4'd5, 28'h1234567);
      rs0 = 4'd5;
      rs1 = 4'd0;
      #1;
      checks++;
      if (dout0 !== 28'h1234567) begin
         failures++;
         $display("FAIL basic_r5 dout0=%h expected 1234567", dout0);
      end
      checks++;
      if (dout1 !== 28'h0) begin
         failures++;
         $display("FAIL basic_r0 dout1=%h expected 0", dout1);
      end
   endtask

   task automatic test_overwrite();
      do_write(4'd5, 28'h0FEDCBA);
      rs0 = 4'd5;
      rs1 = 4'd5;
      #1;
      checks++;
      if (dout0 !== 28'h0FEDCBA || dout1 !== 28'h0FEDCBA) begin
         failures++;
         $display("FAIL overwrite_dual dout0=%h dout1=%h expected 0fedcba 0fedcba", dout0, dout1);
      end
   endtask

   task automatic test_wen_rdw();
      @(negedge clk);
      wen      = 1'b0;
      dest_sel = 4'd3;
      data_in  = 28'hFFFFFFF;
      rs0      = 4'd3;
      @(posedge clk);
      #1;
      checks++;
      if (dout0 !== 28'h0) begin
         failures++;
         $display("FAIL wen_low_r3 dout0=%h expected 0", dout0);
      end
      @(negedge clk);
      wen = 1'b1;
      #1;
      checks++;
      if (dout0 !== 28'h0) begin
         failures++;
         $display("FAIL rdw_before_edge dout0=%h expected 0", dout0);
      end
      @(posedge clk);
      #1;
      wen = 1'b0;
      checks++;
      if (dout0 !== 28'hFFFFFFF) begin
         failures++;
         $display("FAIL rdw_after_edge dout0=%h expected fffffff", dout0);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      dest_sel = 4'd9;
      data_in  = 28'h0000111;
      wen      = 1'b1;
      @(posedge clk);
      #1;
      data_in = 28'h0000222;
      @(posedge clk);
      #1;
      wen = 1'b0;
      rs1 = 4'd9;
      #1;
      checks++;
      if (dout1 !== 28'h0000222) begin
         failures++;
         $display("FAIL back_to_back dout1=%h expected 0000222", dout1);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 1; i < 16; i++) begin
         do_write(4'(i), 28'(i));
      end
      rs0 = 4'd15;
      rs1 = 4'd7;
      #1;
      checks++;
      if (dout0 !== 28'd15 || dout1 !== 28'd7) begin
         failures++;
         $display("FAIL fill dout0=%h dout1=%h expected 000000f 0000007", dout0, dout1);
      end
      @(negedge clk);
      #1;
      rst = 1'b1;
      for (int i = 1; i < 16; i++) begin
         rs0 = 4'(i);
         rs1 = 4'(16 - i);
         #0.2;
         checks++;
         if (dout0 !== 28'h0 || dout1 !== 28'h0) begin
            failures++;
            $display("FAIL async_reset_r%0d dout0=%h dout1=%h expected 0 0", i, dout0, dout1);
         end
      end
      rst = 1'b0;
      do_write(4'd4, 28'h0ABC123);
      rs0 = 4'd4;
      #1;
      checks++;
      if (dout0 !== 28'h0ABC123) begin
         failures++;
         $display("FAIL post_reset_write dout0=%h expected 0abc123", dout0);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      rs0      = 4'd0;
      rs1      = 4'd0;
      data_in  = 28'h0;
      dest_sel = 4'd0;
      wen      = 1'b0;
      test_reset();
      test_r0_protect();
      test_basic();
      test_overwrite();
      test_wen_rdw();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
